// File: rtl/ring_phase_monitor.sv
// Checks a one-hot ring for single-bit-left rotation, declares lock, encodes phase, counts revolutions and losses of lock.
// Latency: every output is registered one clock after the ring_q sample; the block never backpressures the ring.
module ring_phase_monitor #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int REV_W    = 8,
    parameter int ERR_W    = 4,
    localparam int PW      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             res,
    input  logic [WIDTH-1:0] ring_q,
    input  logic             clr_err,
    output logic [PW-1:0]    phase,
    output logic             phase_vld,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             rev_tick,
    output logic [REV_W-1:0] rev_cnt
);

    typedef enum logic {UNLOCK = 1'b0, LOCKED = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [3:0]         good_run_q, good_run_d;
    logic [WIDTH-1:0]   prev_q;
    logic [PW-1:0]      phase_q, phase_d;
    logic               phase_vld_q, locked_q, locked_d;
    logic               err_q, err_d, rev_tick_q, rev_tick_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d, err_base;
    logic [REV_W-1:0]   rev_cnt_q, rev_cnt_d;

    logic               legal, step_ok, wrap;
    logic [WIDTH-1:0]   prev_rot;
    logic [3:0]         good_run_inc;

    assign legal    = $onehot(ring_q);
    assign prev_rot = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
    assign step_ok  = legal && $onehot(prev_q) && (ring_q == prev_rot);
    assign wrap     = step_ok && (ring_q == WIDTH'(1));
    assign good_run_inc = good_run_q + 4'd1;

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q     <= UNLOCK;
            good_run_q  <= '0;
            prev_q      <= '0;
            phase_q     <= '0;
            phase_vld_q <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            rev_tick_q  <= 1'b0;
            rev_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            good_run_q  <= good_run_d;
            prev_q      <= ring_q;
            phase_q     <= phase_d;
            phase_vld_q <= legal;
            locked_q    <= locked_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            rev_tick_q  <= rev_tick_d;
            rev_cnt_q   <= rev_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_run_d = good_run_q;
        case (state_q)
            UNLOCK: begin
                if (!step_ok) begin
                    good_run_d = '0;
                end else if (good_run_inc == 4'(LOCK_CNT)) begin
                    state_d    = LOCKED;
                    good_run_d = '0;
                end else begin
                    good_run_d = good_run_inc;
                end
            end
            LOCKED: begin
                if (!step_ok) begin
                    state_d    = UNLOCK;
                    good_run_d = '0;
                end
            end
            default: begin
                state_d    = UNLOCK;
                good_run_d = '0;
            end
        endcase
    end

    // Clear is applied before the increment, so a coincident loss of lock leaves a count of one.
    always_comb begin
        phase_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (legal && ring_q[i]) phase_d = PW'(i);
        end
        locked_d   = (state_d == LOCKED);
        err_d      = (state_q == LOCKED) && !step_ok;
        rev_tick_d = (state_q == LOCKED) && wrap;
        rev_cnt_d  = rev_cnt_q + REV_W'(rev_tick_d);
        err_base   = clr_err ? '0 : err_cnt_q;
        err_cnt_d  = err_base;
        if (err_d && (err_base != {ERR_W{1'b1}})) err_cnt_d = err_base + ERR_W'(1);
    end

    assign phase     = phase_q;
    assign phase_vld = phase_vld_q;
    assign locked    = locked_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
    assign rev_tick  = rev_tick_q;
    assign rev_cnt   = rev_cnt_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed bench: each stimulus step queues its hand-derived expected outputs; a monitor pops and compares after every edge.
module tb_ring_phase_monitor;

    logic       clk = 1'b0;
    logic       res;
    logic [3:0] ring_q;
    logic       clr_err;
    logic [1:0] phase;
    logic       phase_vld, locked, err, rev_tick;
    logic [3:0] err_cnt;
    logic [1:0] rev_cnt;

    typedef struct packed {
        logic [1:0] ph;
        logic       pv;
        logic       lk;
        logic       er;
        logic [3:0] ec;
        logic       rt;
        logic [1:0] rc;
    } exp_t;

    exp_t exp_q[$];
    int   tag_q[$];
    int   step_no = 0;
    int   checks  = 0;
    int   errors  = 0;

    ring_phase_monitor #(.WIDTH(4), .LOCK_CNT(2), .REV_W(2), .ERR_W(4)) dut (
        .clk(clk), .res(res), .ring_q(ring_q), .clr_err(clr_err),
        .phase(phase), .phase_vld(phase_vld), .locked(locked), .err(err),
        .err_cnt(err_cnt), .rev_tick(rev_tick), .rev_cnt(rev_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [3:0] rq, input logic c,
                        input logic [1:0] ph, input logic pv, input logic lk, input logic er,
                        input logic [3:0] ec, input logic rt, input logic [1:0] rc);
        exp_t e;
        @(negedge clk);
        res = r; ring_q = rq; clr_err = c;
        e.ph = ph; e.pv = pv; e.lk = lk; e.er = er; e.ec = ec; e.rt = rt; e.rc = rc;
        exp_q.push_back(e);
        tag_q.push_back(step_no);
        step_no++;
    endtask

    // Monitor: the DUT presents a fresh output set after every edge.
    always @(posedge clk) begin
        exp_t e;
        int   t;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if ({phase, phase_vld, locked, err, err_cnt, rev_tick, rev_cnt} !== e) begin
                errors++;
                $display("FAIL step%0d: got ph=%0d pv=%b lk=%b err=%b ecnt=%0d tick=%b rcnt=%0d, want ph=%0d pv=%b lk=%b err=%b ecnt=%0d tick=%b rcnt=%0d",
                         t, phase, phase_vld, locked, err, err_cnt, rev_tick, rev_cnt,
                         e.ph, e.pv, e.lk, e.er, e.ec, e.rt, e.rc);
            end
        end
    end

    initial begin
        res = 1'b0; ring_q = 4'b0001; clr_err = 1'b0;

        // Reset, then lock-up from a clean ring.
        step(0, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 4'b0001, 0, 0, 1, 0, 0, 0, 0, 0);
        step(1, 4'b0010, 0, 1, 1, 0, 0, 0, 0, 0);
        step(1, 4'b0100, 0, 2, 1, 1, 0, 0, 0, 0);
        step(1, 4'b1000, 0, 3, 1, 1, 0, 0, 0, 0);
        step(1, 4'b0001, 0, 0, 1, 1, 0, 0, 1, 1);
        step(1, 4'b0010, 0, 1, 1, 1, 0, 0, 0, 1);
        step(1, 4'b0100, 0, 2, 1, 1, 0, 0, 0, 1);

        // Stuck ring, then relock; the wrap on the relock edge is not a revolution.
        step(1, 4'b0100, 0, 2, 1, 0, 1, 1, 0, 1);
        step(1, 4'b1000, 0, 3, 1, 0, 0, 1, 0, 1);
        step(1, 4'b0001, 0, 0, 1, 1, 0, 1, 0, 1);
        step(1, 4'b0010, 0, 1, 1, 1, 0, 1, 0, 1);

        // Multi-hot then all-zero: one err only.
        step(1, 4'b0110, 0, 0, 0, 0, 1, 2, 0, 1);
        step(1, 4'b0000, 0, 0, 0, 0, 0, 2, 0, 1);
        step(1, 4'b0001, 0, 0, 1, 0, 0, 2, 0, 1);
        step(1, 4'b0010, 0, 1, 1, 0, 0, 2, 0, 1);
        step(1, 4'b0100, 0, 2, 1, 1, 0, 2, 0, 1);

        // Fifteen more losses of lock (seventeen total): counter saturates at 15.
        for (int k = 1; k <= 15; k++) begin
            logic [3:0] ec;
            ec = (2 + k > 15) ? 4'd15 : 4'(2 + k);
            step(1, 4'b0000, 0, 0, 0, 0, 1, ec, 0, 1);
            step(1, 4'b0001, 0, 0, 1, 0, 0, ec, 0, 1);
            step(1, 4'b0010, 0, 1, 1, 0, 0, ec, 0, 1);
            step(1, 4'b0100, 0, 2, 1, 1, 0, ec, 0, 1);
        end

        // Clear alone, then clear coincident with a loss of lock.
        step(1, 4'b1000, 1, 3, 1, 1, 0, 0, 0, 1);
        step(1, 4'b1000, 1, 3, 1, 0, 1, 1, 0, 1);
        step(1, 4'b0001, 0, 0, 1, 0, 0, 1, 0, 1);
        step(1, 4'b0010, 0, 1, 1, 1, 0, 1, 0, 1);
        step(1, 4'b0100, 0, 2, 1, 1, 0, 1, 0, 1);
        step(1, 4'b1000, 0, 3, 1, 1, 0, 1, 0, 1);

        // Five revolutions with a 2-bit counter: 2,3,0,1,2.
        for (int r = 0; r < 5; r++) begin
            logic [1:0] rc;
            rc = 2'((2 + r) % 4);
            step(1, 4'b0001, 0, 0, 1, 1, 0, 1, 1, rc);
            if (r < 4) begin
                step(1, 4'b0010, 0, 1, 1, 1, 0, 1, 0, rc);
                step(1, 4'b0100, 0, 2, 1, 1, 0, 1, 0, rc);
                step(1, 4'b1000, 0, 3, 1, 1, 0, 1, 0, rc);
            end
        end

        // Reverse rotation 0001 -> 1000: err without tick, then relock and one more revolution.
        step(1, 4'b1000, 0, 3, 1, 0, 1, 2, 0, 2);
        step(1, 4'b0001, 0, 0, 1, 0, 0, 2, 0, 2);
        step(1, 4'b0010, 0, 1, 1, 1, 0, 2, 0, 2);
        step(1, 4'b0100, 0, 2, 1, 1, 0, 2, 0, 2);
        step(1, 4'b1000, 0, 3, 1, 1, 0, 2, 0, 2);
        step(1, 4'b0001, 0, 0, 1, 1, 0, 2, 1, 3);
        step(1, 4'b0010, 0, 1, 1, 1, 0, 2, 0, 3);

        // Mid-operation reset (rev_cnt=3, err_cnt=2, clr_err also high) and full relock.
        step(0, 4'b0100, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 4'b0100, 0, 2, 1, 0, 0, 0, 0, 0);
        step(1, 4'b1000, 0, 3, 1, 0, 0, 0, 0, 0);
        step(1, 4'b0001, 0, 0, 1, 1, 0, 0, 0, 0);
        step(1, 4'b0010, 0, 1, 1, 1, 0, 0, 0, 0);
        step(1, 4'b0100, 0, 2, 1, 1, 0, 0, 0, 0);
        step(1, 4'b1000, 0, 3, 1, 1, 0, 0, 0, 0);
        step(1, 4'b0001, 0, 0, 1, 1, 0, 0, 1, 1);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected results never compared, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
